// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, instruction field positions and the ID/EX stage-state encoding.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 26;
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FULL   = 2'd1,
      BUBBLE = 2'd2
   } stage_state_e;

   // rt is a source operand only for R-type, branches and stores; I-type ALU ops and loads write it.
   function automatic logic uses_rt(input logic [5:0] opcode);
      return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
             (opcode == OP_BNE)   || (opcode == OP_SW);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: EX (non-load) over MEM over WB over register file; $0 is never forwarded.
module fwd_mux #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_rf_data,
   input  logic          i_ex_wr_en,
   input  logic          i_ex_is_load,
   input  logic [AW-1:0] i_ex_wr_addr,
   input  logic [DW-1:0] i_ex_wr_data,
   input  logic          i_mem_wr_en,
   input  logic [AW-1:0] i_mem_wr_addr,
   input  logic [DW-1:0] i_mem_wr_data,
   input  logic          i_wb_wr_en,
   input  logic [AW-1:0] i_wb_wr_addr,
   input  logic [DW-1:0] i_wb_wr_data,
   output logic [DW-1:0] o_data
);

   always_comb begin
      // NOTE: default assignment first so every path drives o_data and no latch is inferred.
      o_data = i_rf_data;
      if (i_addr != '0) begin
         if (i_ex_wr_en && !i_ex_is_load && (i_ex_wr_addr == i_addr))
            o_data = i_ex_wr_data;
         else if (i_mem_wr_en && (i_mem_wr_addr == i_addr))
            o_data = i_mem_wr_data;
         else if (i_wb_wr_en && (i_wb_wr_addr == i_addr))
            o_data = i_wb_wr_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time forwarding, load-use bubble, valid/ready and flush.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_instr,
   input  logic [DW-1:0] in_pc,
   input  logic [DW-1:0] in_rs_data,
   input  logic [DW-1:0] in_rt_data,
   input  logic          ex_wr_en,
   input  logic [AW-1:0] ex_wr_addr,
   input  logic [DW-1:0] ex_wr_data,
   input  logic          ex_is_load,
   input  logic          mem_wr_en,
   input  logic [AW-1:0] mem_wr_addr,
   input  logic [DW-1:0] mem_wr_data,
   input  logic          wb_wr_en,
   input  logic [AW-1:0] wb_wr_addr,
   input  logic [DW-1:0] wb_wr_data,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_instr,
   output logic [DW-1:0] out_regA,
   output logic [DW-1:0] out_regB,
   output logic [DW-1:0] out_pc
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]   perf_stall_cnt,
   output logic [31:0]   perf_bubble_cnt
`endif
);

   stage_state_e  r_state;
   logic [DW-1:0] r_instr;
   logic [DW-1:0] r_pc;
   logic [DW-1:0] r_reg_a;
   logic [DW-1:0] r_reg_b;

   logic [AW-1:0] w_rs;
   logic [AW-1:0] w_rt;
   logic          w_uses_rt;
   logic          w_hazard;
   logic          w_down_free;
   logic          w_capture;
   logic [DW-1:0] w_fwd_a;
   logic [DW-1:0] w_fwd_b;

   assign w_rs      = in_instr[RS_MSB:RS_LSB];
   assign w_rt      = in_instr[RT_MSB:RT_LSB];
   assign w_uses_rt = uses_rt(in_instr[OP_MSB:OP_LSB]);

   assign w_hazard = in_valid && ex_wr_en && ex_is_load && (ex_wr_addr != '0) &&
                     ((ex_wr_addr == w_rs) || (w_uses_rt && (ex_wr_addr == w_rt)));

   assign out_valid   = (r_state == FULL);
   assign w_down_free = !out_valid || out_ready;
   assign in_ready    = flush || (!w_hazard && w_down_free);
   assign w_capture   = in_valid && in_ready && !flush;

   assign out_instr = r_instr;
   assign out_pc    = r_pc;
   assign out_regA  = r_reg_a;
   assign out_regB  = r_reg_b;

   fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
      .i_addr(w_rs), .i_rf_data(in_rs_data),
      .i_ex_wr_en(ex_wr_en), .i_ex_is_load(ex_is_load),
      .i_ex_wr_addr(ex_wr_addr), .i_ex_wr_data(ex_wr_data),
      .i_mem_wr_en(mem_wr_en), .i_mem_wr_addr(mem_wr_addr), .i_mem_wr_data(mem_wr_data),
      .i_wb_wr_en(wb_wr_en), .i_wb_wr_addr(wb_wr_addr), .i_wb_wr_data(wb_wr_data),
      .o_data(w_fwd_a)
   );

   fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
      .i_addr(w_rt), .i_rf_data(in_rt_data),
      .i_ex_wr_en(ex_wr_en), .i_ex_is_load(ex_is_load),
      .i_ex_wr_addr(ex_wr_addr), .i_ex_wr_data(ex_wr_data),
      .i_mem_wr_en(mem_wr_en), .i_mem_wr_addr(mem_wr_addr), .i_mem_wr_data(mem_wr_data),
      .i_wb_wr_en(wb_wr_en), .i_wb_wr_addr(wb_wr_addr), .i_wb_wr_data(wb_wr_data),
      .o_data(w_fwd_b)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: payload registers are reset too because the outputs must read zero after reset.
         r_state <= EMPTY;
         r_instr <= '0;
         r_pc    <= '0;
         r_reg_a <= '0;
         r_reg_b <= '0;
      end else if (flush) begin
         r_state <= EMPTY;
      end else if (w_hazard && w_down_free) begin
         r_state <= BUBBLE;
      end else if (w_capture) begin
         r_state <= FULL;
         r_instr <= in_instr;
         r_pc    <= in_pc;
         r_reg_a <= w_fwd_a;
         r_reg_b <= w_fwd_b;
      end else if (w_down_free) begin
         // Entry consumed with nothing new, or a bubble/empty slot with no incoming instruction.
         r_state <= EMPTY;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_bubble_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (!flush && w_hazard && w_down_free)
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt  = r_stall_cnt;
   assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage: forwarding vectors plus load-use, stall, flush and reset sequences.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   localparam logic [31:0] I_ADD  = 32'h00221820; // add  $3,$1,$2
   localparam logic [31:0] I_SUB  = 32'h00222022; // sub  $4,$1,$2
   localparam logic [31:0] I_ADDI0 = 32'h20050001; // addi $5,$0,1
   localparam logic [31:0] I_ADDI6 = 32'h20260001; // addi $6,$1,1
   localparam logic [31:0] I_SLL  = 32'h00021900; // sll  $3,$2,4
   localparam logic [31:0] I_SW   = 32'hAC220004; // sw   $2,4($1)
   localparam logic [31:0] I_BEQ  = 32'h10220000; // beq  $1,$2,0

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_instr, in_pc, in_rs_data, in_rt_data;
   logic          ex_wr_en, ex_is_load;
   logic [AW-1:0] ex_wr_addr;
   logic [DW-1:0] ex_wr_data;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic          wb_wr_en;
   logic [AW-1:0] wb_wr_addr;
   logic [DW-1:0] wb_wr_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_instr, out_regA, out_regB, out_pc;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0]   perf_stall_cnt, perf_bubble_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_regA(out_regA), .out_regB(out_regB), .out_pc(out_pc)
`ifdef ID_EX_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   typedef struct {
      logic [31:0]   instr, pc, rs_data, rt_data;
      logic          ex_en, ex_ld;
      logic [AW-1:0] ex_addr;
      logic [31:0]   ex_data;
      logic          mem_en;
      logic [AW-1:0] mem_addr;
      logic [31:0]   mem_data;
      logic          wb_en;
      logic [AW-1:0] wb_addr;
      logic [31:0]   wb_data;
      logic [31:0]   exp_a, exp_b;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_fwd();
      ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = '0; ex_wr_data = '0;
      mem_wr_en = 0; mem_wr_addr = '0; mem_wr_data = '0;
      wb_wr_en = 0; wb_wr_addr = '0; wb_wr_data = '0;
   endtask

   task automatic drive_instr(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] rs_d, input logic [31:0] rt_d);
      in_valid = 1; in_instr = instr; in_pc = pc; in_rs_data = rs_d; in_rt_data = rt_d;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{I_ADD,   32'h100, 32'h5,  32'h7,  0,0,5'd0,32'h0,     0,5'd0,32'h0,    0,5'd0,32'h0,    32'h5,  32'h7};
      vecs[1] = '{I_ADD,   32'h104, 32'h5,  32'h7,  1,0,5'd1,32'h10,    1,5'd1,32'h20,   0,5'd0,32'h0,    32'h10, 32'h7};
      vecs[2] = '{I_ADD,   32'h108, 32'hA,  32'hB,  0,0,5'd0,32'h0,     1,5'd2,32'h30,   1,5'd2,32'h40,   32'hA,  32'h30};
      vecs[3] = '{I_ADD,   32'h10C, 32'hA,  32'hB,  1,0,5'd5,32'h99,    0,5'd0,32'h0,    1,5'd1,32'h50,   32'h50, 32'hB};
      vecs[4] = '{I_ADDI0, 32'h110, 32'h0,  32'h9,  1,0,5'd0,32'h1234,  1,5'd0,32'h5678, 1,5'd0,32'hFFFF, 32'h0,  32'h9};
      vecs[5] = '{I_ADDI6, 32'h114, 32'h11, 32'h22, 1,1,5'd6,32'hDEAD,  1,5'd6,32'h66,   0,5'd0,32'h0,    32'h11, 32'h66};
      vecs[6] = '{I_SLL,   32'h118, 32'h5,  32'h33, 1,0,5'd2,32'h77,    0,5'd0,32'h0,    1,5'd0,32'h1,    32'h5,  32'h77};
      vecs[7] = '{I_SW,    32'h11C, 32'h1,  32'h2,  1,0,5'd2,32'hE2,    1,5'd2,32'hE3,   1,5'd1,32'hB1,   32'hB1, 32'hE2};

      rst = 1; flush = 0; out_ready = 1; clear_fwd();
      drive_instr(I_ADD, 32'h100, 32'h5, 32'h7);
      after_edge();
      after_edge();
      check("reset out_valid", {31'b0, out_valid}, 32'h0);
      check("reset out_instr", out_instr, 32'h0);
      check("reset out_regA",  out_regA,  32'h0);
      check("reset out_regB",  out_regB,  32'h0);
      check("reset out_pc",    out_pc,    32'h0);
`ifdef ID_EX_PERF_CNT_EN
      check("reset perf_stall",  perf_stall_cnt,  32'h0);
      check("reset perf_bubble", perf_bubble_cnt, 32'h0);
`endif
      @(negedge clk);
      rst = 0;

      // Back-to-back captures with out_ready held high; each vector exercises one forwarding case.
      for (int i = 0; i < 8; i++) begin
         drive_instr(vecs[i].instr, vecs[i].pc, vecs[i].rs_data, vecs[i].rt_data);
         ex_wr_en = vecs[i].ex_en; ex_is_load = vecs[i].ex_ld;
         ex_wr_addr = vecs[i].ex_addr; ex_wr_data = vecs[i].ex_data;
         mem_wr_en = vecs[i].mem_en; mem_wr_addr = vecs[i].mem_addr; mem_wr_data = vecs[i].mem_data;
         wb_wr_en = vecs[i].wb_en; wb_wr_addr = vecs[i].wb_addr; wb_wr_data = vecs[i].wb_data;
         #1;
         check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, 32'h1);
         after_edge();
         check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'h1);
         check($sformatf("vec%0d out_instr", i), out_instr, vecs[i].instr);
         check($sformatf("vec%0d out_pc", i),    out_pc,    vecs[i].pc);
         check($sformatf("vec%0d regA", i),      out_regA,  vecs[i].exp_a);
         check($sformatf("vec%0d regB", i),      out_regB,  vecs[i].exp_b);
         @(negedge clk);
      end

      // Load-use on rt: bubble, then the load value arrives from MEM.
      clear_fwd();
      drive_instr(I_SUB, 32'h200, 32'h1, 32'h2);
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd2; ex_wr_data = 32'hBAD;
      #1;
      check("lu_rt in_ready", {31'b0, in_ready}, 32'h0);
      after_edge();
      check("lu_rt bubble out_valid", {31'b0, out_valid}, 32'h0);
      @(negedge clk);
      clear_fwd();
      mem_wr_en = 1; mem_wr_addr = 5'd2; mem_wr_data = 32'hABCD;
      #1;
      check("lu_rt retry in_ready", {31'b0, in_ready}, 32'h1);
      after_edge();
      check("lu_rt out_valid", {31'b0, out_valid}, 32'h1);
      check("lu_rt out_instr", out_instr, I_SUB);
      check("lu_rt regA", out_regA, 32'h1);
      check("lu_rt regB", out_regB, 32'hABCD);

      // Load-use on rs, then decode goes idle: bubble collapses to empty.
      @(negedge clk);
      clear_fwd();
      drive_instr(I_BEQ, 32'h240, 32'h3, 32'h4);
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd1;
      #1;
      check("lu_rs in_ready", {31'b0, in_ready}, 32'h0);
      after_edge();
      check("lu_rs bubble out_valid", {31'b0, out_valid}, 32'h0);
      @(negedge clk);
      clear_fwd();
      in_valid = 0;
      after_edge();
      check("bubble idle out_valid", {31'b0, out_valid}, 32'h0);
      after_edge();
      check("empty idle out_valid", {31'b0, out_valid}, 32'h0);
`ifdef ID_EX_PERF_CNT_EN
      check("perf_bubble after lu", perf_bubble_cnt, 32'd2);
`endif

      // Refill, then hold out_ready low for three cycles with a new instruction waiting.
      @(negedge clk);
      drive_instr(I_ADD, 32'h300, 32'h5, 32'h7);
      after_edge();
      check("refill out_valid", {31'b0, out_valid}, 32'h1);
      @(negedge clk);
      out_ready = 0;
      drive_instr(I_SUB, 32'h304, 32'h8, 32'h9);
      wb_wr_en = 1; wb_wr_addr = 5'd1; wb_wr_data = 32'h77;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall%0d in_ready", c), {31'b0, in_ready}, 32'h0);
         after_edge();
         check($sformatf("stall%0d out_valid", c), {31'b0, out_valid}, 32'h1);
         check($sformatf("stall%0d out_pc", c),    out_pc,   32'h300);
         check($sformatf("stall%0d regA", c),      out_regA, 32'h5);
         @(negedge clk);
      end
`ifdef ID_EX_PERF_CNT_EN
      check("perf_stall", perf_stall_cnt, 32'd3);
`endif
      out_ready = 1;
      clear_fwd();
      #1;
      check("unstall in_ready", {31'b0, in_ready}, 32'h1);
      after_edge();
      check("unstall out_pc", out_pc, 32'h304);
      check("unstall regA", out_regA, 32'h8);

      // Flush while full with a valid incoming instruction.
      @(negedge clk);
      flush = 1;
      drive_instr(I_ADD, 32'h400, 32'h1, 32'h1);
      #1;
      check("flush in_ready", {31'b0, in_ready}, 32'h1);
      after_edge();
      check("flush out_valid", {31'b0, out_valid}, 32'h0);
      check("flush out_pc held", out_pc, 32'h304);

      // Refill, then flush together with a load-use hazard.
      @(negedge clk);
      flush = 0;
      drive_instr(I_ADD, 32'h404, 32'h2, 32'h3);
      after_edge();
      check("post-flush capture out_pc", out_pc, 32'h404);
      @(negedge clk);
      flush = 1;
      drive_instr(I_ADD, 32'h408, 32'h4, 32'h5);
      ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd1;
      #1;
      check("flush+hazard in_ready", {31'b0, in_ready}, 32'h1);
      after_edge();
      check("flush+hazard out_valid", {31'b0, out_valid}, 32'h0);
      check("flush+hazard out_pc", out_pc, 32'h404);
`ifdef ID_EX_PERF_CNT_EN
      check("perf_bubble after flush", perf_bubble_cnt, 32'd2);
`endif

      // Reset while full clears the payload.
      @(negedge clk);
      flush = 0;
      clear_fwd();
      drive_instr(I_SW, 32'h40C, 32'h6, 32'h7);
      after_edge();
      check("pre-reset out_valid", {31'b0, out_valid}, 32'h1);
      @(negedge clk);
      rst = 1;
      after_edge();
      check("mid reset out_valid", {31'b0, out_valid}, 32'h0);
      check("mid reset out_pc",   out_pc,   32'h0);
      check("mid reset out_regA", out_regA, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
